// File: rtl/analog_project_sel.sv
// Break-before-make selector for analog projects sharing the user IO pads.
// Optional sticky request lock is enabled by defining ANALOG_SEL_LOCK_EN.
module analog_project_sel #(
    parameter int NUM_PROJ      = 8,
    parameter int GUARD_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                sel_valid,
    input  logic [3:0]          sel_id,
`ifdef ANALOG_SEL_LOCK_EN
    input  logic                sel_lock,
`endif
    output logic                sel_ready,
    output logic [NUM_PROJ-1:0] active,
    output logic [3:0]          cur_id,
    output logic                busy,
    output logic                sel_done,
    output logic                sel_err
);

    localparam logic [3:0] NONE_ID     = 4'hF;
    localparam logic [3:0] NUM_PROJ_ID = 4'(NUM_PROJ);
    localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, BREAK, SETTLE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] target;
    logic       xfer;
    logic       req_proj;
    logic       req_none;
    logic       req_same;
    logic       req_locked;

    function automatic logic [NUM_PROJ-1:0] onehot(input logic [3:0] idx);
        logic [NUM_PROJ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PROJ; i++) begin
            v[i] = (idx == 4'(i));
        end
        return v;
    endfunction

    assign sel_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = sel_valid && sel_ready;
    assign req_proj  = (sel_id < NUM_PROJ_ID);
    assign req_none  = (sel_id == NONE_ID);
    assign req_same  = (sel_id == cur_id);

`ifdef ANALOG_SEL_LOCK_EN
    logic locked;
    assign req_locked = locked;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            locked <= 1'b0;
        end else if (state == IDLE && sel_lock) begin
            locked <= 1'b1;
        end
    end
`else
    assign req_locked = 1'b0;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // every state element, including the counter and target, is cleared by it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            target   <= NONE_ID;
            active   <= '0;
            cur_id   <= NONE_ID;
            sel_done <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            sel_done <= 1'b0;
            sel_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (req_locked) begin
                            sel_err <= 1'b1;
                        end else if (req_same) begin
                            sel_done <= 1'b1;
                        end else if (req_proj || req_none) begin
                            // Outputs drop at transfer: the guard window starts all-zero.
                            state  <= BREAK;
                            cnt    <= GUARD_LOAD;
                            target <= sel_id;
                            active <= '0;
                            cur_id <= NONE_ID;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else if (target == NONE_ID) begin
                        state    <= IDLE;
                        cnt      <= 8'd0;
                        sel_done <= 1'b1;
                    end else begin
                        state  <= SETTLE;
                        cnt    <= SETTLE_LOAD;
                        active <= onehot(target);
                        cur_id <= target;
                    end
                end
                SETTLE: begin
                    if (cnt > 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state    <= IDLE;
                        cnt      <= 8'd0;
                        sel_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/analog_project_sel.md
ANALOG_PROJECT_SEL -- requirements
Module: analog_project_sel

Interface
REQ-001 Parameter NUM_PROJ, 8, number of analog projects sharing the user IO pads; legal 1..15.
REQ-002 Parameter GUARD_CYCLES, 16, break-before-make dead time (all projects inactive); legal 1..255.
REQ-003 Parameter SETTLE_CYCLES, 32, post-enable settle time before the controller reports done; legal 1..255.
REQ-004 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 sel_valid  input  1  select request valid.
REQ-007 sel_id  input  4  requested project index; 4'hF = deselect all.
REQ-008 sel_ready  output  1  controller can accept a request.
REQ-009 active  output  NUM_PROJ  one-hot (or all-zero) enable, one bit per project wrapper's active input.
REQ-010 cur_id  output  4  index of the currently enabled project; 4'hF when none.
REQ-011 busy  output  1  a switch sequence is in progress.
REQ-012 sel_done  output  1  one-cycle pulse when a sequence completes.
REQ-013 sel_err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-014 Handshake: a request transfers on a cycle with sel_valid=1 and sel_ready=1; sel_ready SHALL equal (state==IDLE); sel_id is sampled only at transfer.
REQ-015 FSM states IDLE, BREAK, SETTLE; transitions IDLE->BREAK on an accepted legal switch request, BREAK->SETTLE when the guard counter expires and the target is 0..NUM_PROJ-1, BREAK->IDLE when it expires and the target is 4'hF, SETTLE->IDLE when the settle counter expires.
REQ-016 Timing, transfer at cycle 0: active SHALL be all-zero and busy=1 during cycles 1..GUARD_CYCLES.
REQ-017 At cycle GUARD_CYCLES+1, active SHALL equal one-hot(target) and cur_id SHALL equal target; active SHALL hold this value during SETTLE.
REQ-018 For a target project, busy SHALL fall, sel_ready SHALL rise and sel_done SHALL pulse at cycle GUARD_CYCLES+SETTLE_CYCLES+1.
REQ-019 For target 4'hF, cur_id SHALL become 4'hF at cycle 1, and busy SHALL fall, sel_ready SHALL rise and sel_done SHALL pulse at cycle GUARD_CYCLES+1.
REQ-020 Request equal to cur_id (including 4'hF when none active): accepted, no BREAK, active unchanged, sel_done pulses at cycle 1, sel_ready remains 1.
REQ-021 Request with sel_id in NUM_PROJ..14: accepted, no state change, sel_err pulses at cycle 1, sel_done not asserted.
REQ-022 active SHALL never have more than one bit set, and no bit SHALL ever change directly from one project to another without at least GUARD_CYCLES all-zero cycles.
REQ-023 sel_valid while busy SHALL be ignored (not queued); requester holds it until sel_ready.
REQ-024 Counters SHALL be 8 bits, load at state entry, count down to 1, and never wrap.

Reset
REQ-025 While wb_rst_i=1 at a clock edge: state=IDLE, active=0, cur_id=4'hF, busy=0, sel_ready=1 from the following cycle, sel_done=0, sel_err=0, counters=0.
REQ-026 Reset asserted mid-BREAK or mid-SETTLE SHALL abort the sequence with the values of REQ-025 on the next cycle; no sel_done is issued for the aborted sequence.

Configuration
REQ-027 Macro ANALOG_SEL_LOCK_EN: when defined, the block adds input sel_lock (1 bit); sel_lock=1 sampled in IDLE sets a sticky lock cleared only by reset; while locked, every request is accepted, causes no state change, and pulses sel_err at cycle 1.
REQ-028 Without ANALOG_SEL_LOCK_EN, the sel_lock port and lock register SHALL not exist and the behaviour is exactly REQ-014..REQ-026.

Verification (GUARD_CYCLES=4, SETTLE_CYCLES=8, NUM_PROJ=8)
REQ-029 Reset, then request sel_id=3 at cycle 0 -> active=0 at cycles 1..4, active=8'h08 and cur_id=3 from cycle 5, sel_done at cycle 13, sel_ready=1 at cycle 13.
REQ-030 With project 3 active, request 5 -> active 8'h08 to 8'h00 at cycle 1, 8'h20 at cycle 5, never 8'h28; sel_valid pulses at cycles 2..12 are ignored.
REQ-031 Request sel_id=9 -> sel_err at cycle 1, active/cur_id unchanged, no busy; request sel_id=cur_id -> sel_done at cycle 1, no break.
REQ-032 With project 5 active, request 4'hF -> active=0 and cur_id=4'hF from cycle 1, sel_done at cycle 5.
REQ-033 Assert wb_rst_i at cycle 6 of a switch to project 2 -> next cycle active=0, cur_id=4'hF, busy=0, no sel_done.
REQ-034 With ANALOG_SEL_LOCK_EN: select 1, assert sel_lock in IDLE, request 6 -> sel_err at cycle 1, active stays 8'h02 until reset.
